// File: rtl/drive_z_corr_loader_if.sv
// Host correction-word stream: valid/ready beats carrying bank, row, data and last.
interface drive_z_corr_loader_if #(
  parameter int BANK_SEL_WIDTH            = 2,
  parameter int QUBIT_ADDR_WIDTH_PER_BANK = 4,
  parameter int Z_CORR_WIDTH              = 12
);
  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [BANK_SEL_WIDTH-1:0]            cfg_bank;
  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] cfg_addr;
  logic [Z_CORR_WIDTH-1:0]              cfg_data;
  logic                                 cfg_last;

  modport master (output cfg_valid, cfg_bank, cfg_addr, cfg_data, cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, cfg_bank, cfg_addr, cfg_data, cfg_last, output cfg_ready);
endinterface

// File: rtl/drive_z_corr_loader.sv
// Assembles host correction words into one table row, stalls the target bank's reads,
// then issues a single write beat. Optional broadcast to all banks: Z_CORR_LOAD_BROADCAST_EN.
module drive_z_corr_loader #(
  parameter int NUM_BANK                  = 2,
  parameter int NUM_QUBIT_PER_BANK        = 16,
  parameter int QUBIT_ADDR_WIDTH_PER_BANK = 4,
  parameter int Z_CORR_WIDTH              = 12,
  parameter int BANK_SEL_WIDTH            = 2,
  parameter int STALL_LAT                 = 2,
  localparam int TOTAL_QUBIT              = NUM_QUBIT_PER_BANK * NUM_BANK,
  localparam int DATA_WIDTH               = Z_CORR_WIDTH * TOTAL_QUBIT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  drive_z_corr_loader_if.slave                 cfg,
  input  logic [NUM_BANK-1:0]                  valid_inst_list_in,
  output logic [NUM_BANK-1:0]                  z_corr_memory_wr_sel,
  output logic                                 z_corr_memory_wr_en,
  output logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] z_corr_memory_wr_addr,
  output logic [DATA_WIDTH-1:0]                z_corr_memory_wr_data,
  output logic [NUM_BANK-1:0]                  inst_stall_out,
  output logic                                 load_busy,
  output logic                                 load_done,
  output logic [1:0]                           load_err,
  input  logic                                 err_clr
);

  localparam int CNT_W = $clog2(TOTAL_QUBIT + 1);
  localparam int LAT_W = $clog2(STALL_LAT + 1);

  typedef enum logic [1:0] {IDLE, FILL, STALL, WRITE} state_t;

  state_t                               state_q;
  logic [CNT_W-1:0]                     word_cnt_q;
  logic [LAT_W-1:0]                     lat_cnt_q;
  logic [BANK_SEL_WIDTH-1:0]            bank_q;
  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] addr_q;
  logic [DATA_WIDTH-1:0]                row_q;
  logic [NUM_BANK-1:0]                  mask_q;
  logic                                 ready_q;
  logic [NUM_BANK-1:0]                  wr_sel_q;
  logic                                 wr_en_q;
  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]                wr_data_q;
  logic [NUM_BANK-1:0]                  stall_q;
  logic                                 busy_q;
  logic                                 done_q;
  logic [1:0]                           err_q;

  logic                                 beat_d;
  logic                                 idle_d;
  logic [CNT_W-1:0]                     slot_d;
  logic [BANK_SEL_WIDTH-1:0]            bank_d;
  logic                                 full_d;
  logic                                 close_d;
  logic [DATA_WIDTH-1:0]                row_d;
  logic [NUM_BANK-1:0]                  mask_d;
  logic                                 bank_ok_d;
  logic [1:0]                           err_set_d;

  // Bank and slot come from the live beat on a row's first word, else from the latched row.
  always_comb begin
    beat_d  = cfg.cfg_valid & ready_q;
    idle_d  = (state_q == IDLE);
    slot_d  = idle_d ? '0 : word_cnt_q;
    bank_d  = idle_d ? cfg.cfg_bank : bank_q;
    full_d  = (slot_d == CNT_W'(TOTAL_QUBIT - 1));
    close_d = beat_d & (cfg.cfg_last | full_d);
    row_d   = idle_d ? '0 : row_q;
    row_d[int'(slot_d)*Z_CORR_WIDTH +: Z_CORR_WIDTH] = cfg.cfg_data;
    mask_d  = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (int'(bank_d) == b) mask_d[b] = 1'b1;
    end
`ifdef Z_CORR_LOAD_BROADCAST_EN
    if (&bank_d) mask_d = '1;
`endif
    bank_ok_d    = |mask_d;
    err_set_d[0] = close_d & ((full_d & ~cfg.cfg_last) | ~bank_ok_d);
    err_set_d[1] = (state_q == WRITE) & (|(valid_inst_list_in & mask_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      lat_cnt_q  <= '0;
      bank_q     <= '0;
      addr_q     <= '0;
      row_q      <= '0;
      mask_q     <= '0;
      ready_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      stall_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= (err_clr ? 2'b00 : err_q) | err_set_d;
      unique case (state_q)
        IDLE, FILL: begin
          if (beat_d) begin
            row_q      <= row_d;
            word_cnt_q <= slot_d + CNT_W'(1);
            if (idle_d) begin
              bank_q <= cfg.cfg_bank;
              addr_q <= cfg.cfg_addr;
            end
            if (close_d && bank_ok_d) begin
              state_q   <= STALL;
              mask_q    <= mask_d;
              stall_q   <= mask_d;
              lat_cnt_q <= '0;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
            end else if (close_d) begin
              // Unwritable bank: the row is dropped and the host may start over at once.
              state_q    <= IDLE;
              row_q      <= '0;
              word_cnt_q <= '0;
              ready_q    <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q <= FILL;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
            busy_q  <= !idle_d;
          end
        end
        STALL: begin
          if (lat_cnt_q == LAT_W'(STALL_LAT - 1)) begin
            state_q   <= WRITE;
            wr_en_q   <= 1'b1;
            wr_sel_q  <= mask_q;
            wr_addr_q <= addr_q;
            wr_data_q <= row_q;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        WRITE: begin
          if (err_set_d[1]) begin
            // A read slipped through the stall: keep stalling and rewrite the row.
            state_q   <= STALL;
            lat_cnt_q <= '0;
          end else begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            stall_q    <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            row_q      <= '0;
            word_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign cfg.cfg_ready             = ready_q;
  assign z_corr_memory_wr_sel      = wr_sel_q;
  assign z_corr_memory_wr_en       = wr_en_q;
  assign z_corr_memory_wr_addr     = wr_addr_q;
  assign z_corr_memory_wr_data     = wr_data_q;
  assign inst_stall_out            = stall_q;
  assign load_busy                 = busy_q;
  assign load_done                 = done_q;
  assign load_err                  = err_q;

endmodule

// File: tb/tb_drive_z_corr_loader.sv
// Randomized self-checking bench for drive_z_corr_loader against a word-list row model.
module tb_drive_z_corr_loader;
  localparam int NB = 2;
  localparam int AW = 4;
  localparam int ZW = 12;
  localparam int BW = 2;
  localparam int SL = 2;
  localparam int TQ = 32;
  localparam int DW = ZW * TQ;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drive_z_corr_loader_if #(.BANK_SEL_WIDTH(BW), .QUBIT_ADDR_WIDTH_PER_BANK(AW), .Z_CORR_WIDTH(ZW)) ifc ();

  logic [NB-1:0] vil = '0;
  logic [NB-1:0] wr_sel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] stall;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic          err_clr = 1'b0;

  drive_z_corr_loader dut (
    .clk                   (clk),
    .rst                   (rst),
    .cfg                   (ifc),
    .valid_inst_list_in    (vil),
    .z_corr_memory_wr_sel  (wr_sel),
    .z_corr_memory_wr_en   (wr_en),
    .z_corr_memory_wr_addr (wr_addr),
    .z_corr_memory_wr_data (wr_data),
    .inst_stall_out        (stall),
    .load_busy             (busy),
    .load_done             (done),
    .load_err              (err),
    .err_clr               (err_clr)
  );

  int nchk  = 0;
  int npass = 0;
  bit gaps  = 1'b0;

  logic [ZW-1:0] words [TQ];
  logic [NB-1:0] o_stall [16];
  logic          o_en    [16];
  logic [NB-1:0] o_sel   [16];
  logic [AW-1:0] o_addr  [16];
  logic [DW-1:0] o_data  [16];
  logic          o_done  [16];
  logic          o_ready [16];
  logic          o_busy  [16];
  logic [1:0]    o_err   [16];

  // Reference row: word i occupies bits starting at i*ZW, unused slots zero.
  function automatic logic [DW-1:0] model_row(input int n);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = r | (DW'(words[i]) << (i * ZW));
    return r;
  endfunction

  function automatic logic [NB-1:0] onehot(input int b);
    return NB'(1) << b;
  endfunction

  task automatic beat(input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [ZW-1:0] d, input logic l);
    int g;
    g = 0;
    @(negedge clk);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    while (ifc.cfg_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      nchk++;
      $display("FAIL ready_timeout cfg_ready=%b required 1", ifc.cfg_ready);
    end
    ifc.cfg_valid = 1'b1;
    ifc.cfg_bank  = b;
    ifc.cfg_addr  = a;
    ifc.cfg_data  = d;
    ifc.cfg_last  = l;
    @(posedge clk);
    #1;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_last  = 1'b0;
  endtask

  task automatic send_row(input logic [BW-1:0] b, input logic [AW-1:0] a, input int n, input logic last_final);
    for (int i = 0; i < n; i++) beat(b, a, words[i], last_final && (i == n - 1));
  endtask

  task automatic observe(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      o_stall[k] = stall;  o_en[k]   = wr_en;  o_sel[k]   = wr_sel;
      o_addr[k]  = wr_addr; o_data[k] = wr_data; o_done[k] = done;
      o_ready[k] = ifc.cfg_ready; o_busy[k] = busy; o_err[k] = err;
    end
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nchk++;
    if ({ifc.cfg_ready, wr_en, wr_sel, stall, busy, done, err} !== '0)
      $display("FAIL reset_outputs got %b required 0", {ifc.cfg_ready, wr_en, wr_sel, stall, busy, done, err});
    else npass++;
    nchk++;
    if (wr_data !== '0 || wr_addr !== '0) $display("FAIL reset_wr_bus got addr=%h data=%h required 0", wr_addr, wr_data);
    else npass++;
    rst = 1'b0;
    @(negedge clk);
    nchk++;
    if (ifc.cfg_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release ready=%b busy=%b required 1/0", ifc.cfg_ready, busy);
    else npass++;
  endtask

  task automatic test_full_row();
    logic [DW-1:0] exp;
    for (int i = 0; i < TQ; i++) words[i] = ZW'(i + 1);
    exp = model_row(TQ);
    vil = 2'b01;
    send_row(2'd1, 4'd5, TQ, 1'b1);
    observe(SL + 2);
    vil = 2'b00;
    for (int k = 1; k <= SL + 2; k++) begin
      nchk++;
      if (o_stall[k] !== ((k <= SL + 1) ? 2'b10 : 2'b00)) $display("FAIL full_stall k=%0d got %b", k, o_stall[k]);
      else npass++;
      nchk++;
      if (o_en[k] !== (k == SL + 1)) $display("FAIL full_wr_en k=%0d got %b required %b", k, o_en[k], (k == SL + 1));
      else npass++;
      nchk++;
      if (o_done[k] !== (k == SL + 2)) $display("FAIL full_done k=%0d got %b required %b", k, o_done[k], (k == SL + 2));
      else npass++;
    end
    nchk++;
    if (o_sel[SL+1] !== 2'b10 || o_addr[SL+1] !== 4'd5) $display("FAIL full_sel_addr got %b/%0d required 10/5", o_sel[SL+1], o_addr[SL+1]);
    else npass++;
    nchk++;
    if (o_data[SL+1] !== exp) $display("FAIL full_data got %h required %h", o_data[SL+1], exp);
    else npass++;
    nchk++;
    if (o_ready[1] !== 1'b0 || o_ready[SL+2] !== 1'b1 || o_err[SL+2] !== 2'b00)
      $display("FAIL full_ready_err ready1=%b readyE=%b err=%b required 0/1/00", o_ready[1], o_ready[SL+2], o_err[SL+2]);
    else npass++;
    nchk++;
    if (o_sel[SL+2] !== '0 || o_data[SL+2] !== '0) $display("FAIL full_bus_idle sel=%b required 0 when wr_en=0", o_sel[SL+2]);
    else npass++;
  endtask

  task automatic test_short_row();
    words[0] = 12'hABC;
    words[1] = 12'h123;
    send_row(2'd0, 4'd3, 2, 1'b1);
    observe(SL + 2);
    nchk++;
    if (o_en[SL+1] !== 1'b1 || o_sel[SL+1] !== 2'b01 || o_addr[SL+1] !== 4'd3)
      $display("FAIL short_write en=%b sel=%b addr=%0d required 1/01/3", o_en[SL+1], o_sel[SL+1], o_addr[SL+1]);
    else npass++;
    nchk++;
    if (o_data[SL+1] !== DW'(24'h123ABC)) $display("FAIL short_data got %h required 123abc", o_data[SL+1]);
    else npass++;
    nchk++;
    if (o_err[SL+2] !== 2'b00 || o_done[SL+2] !== 1'b1) $display("FAIL short_err_done err=%b done=%b required 00/1", o_err[SL+2], o_done[SL+2]);
    else npass++;
  endtask

  task automatic test_random_rows();
    logic [DW-1:0] exp;
    int b, n;
    logic [AW-1:0] a;
    gaps = 1'b1;
    for (int r = 0; r < 8; r++) begin
      b = $urandom_range(0, NB - 1);
      n = $urandom_range(1, TQ);
      a = AW'($urandom);
      for (int i = 0; i < TQ; i++) words[i] = ZW'($urandom);
      exp = model_row(n);
      vil = ~onehot(b);
      send_row(BW'(b), a, n, 1'b1);
      observe(SL + 2);
      vil = '0;
      for (int k = 1; k <= SL + 2; k++) begin
        nchk++;
        if (o_stall[k] !== ((k <= SL + 1) ? onehot(b) : '0) || o_en[k] !== (k == SL + 1) || o_done[k] !== (k == SL + 2))
          $display("FAIL rand_timeline row=%0d k=%0d stall=%b en=%b done=%b", r, k, o_stall[k], o_en[k], o_done[k]);
        else npass++;
      end
      nchk++;
      if (o_sel[SL+1] !== onehot(b) || o_addr[SL+1] !== a || o_data[SL+1] !== exp)
        $display("FAIL rand_write row=%0d sel=%b addr=%0d data=%h required %b/%0d/%h", r, o_sel[SL+1], o_addr[SL+1], o_data[SL+1], onehot(b), a, exp);
      else npass++;
    end
    gaps = 1'b0;
  endtask

  task automatic test_bad_bank();
    words[0] = 12'h5A5;
    words[1] = 12'h0F0;
    send_row(2'd2, 4'd7, 2, 1'b1);
    observe(SL + 2);
    for (int k = 1; k <= SL + 2; k++) begin
      nchk++;
      if (o_en[k] !== 1'b0 || o_stall[k] !== '0 || o_done[k] !== 1'b0)
        $display("FAIL bank2_nowrite k=%0d en=%b stall=%b done=%b required 0", k, o_en[k], o_stall[k], o_done[k]);
      else npass++;
    end
    nchk++;
    if (o_err[1] !== 2'b01 || o_ready[1] !== 1'b1 || o_busy[1] !== 1'b0)
      $display("FAIL bank2_err err=%b ready=%b busy=%b required 01/1/0", o_err[1], o_ready[1], o_busy[1]);
    else npass++;
    pulse_err_clr();
    nchk++;
    if (err !== 2'b00) $display("FAIL err_clr got %b required 00", err);
    else npass++;
    send_row(2'd3, 4'd9, 2, 1'b1);
    observe(SL + 2);
`ifdef Z_CORR_LOAD_BROADCAST_EN
    nchk++;
    if (o_stall[1] !== 2'b11 || o_stall[SL+1] !== 2'b11 || o_stall[SL+2] !== 2'b00)
      $display("FAIL bcast_stall got %b %b %b required 11 11 00", o_stall[1], o_stall[SL+1], o_stall[SL+2]);
    else npass++;
    nchk++;
    if (o_en[SL+1] !== 1'b1 || o_sel[SL+1] !== 2'b11 || o_addr[SL+1] !== 4'd9 || o_data[SL+1] !== model_row(2))
      $display("FAIL bcast_write en=%b sel=%b addr=%0d data=%h", o_en[SL+1], o_sel[SL+1], o_addr[SL+1], o_data[SL+1]);
    else npass++;
    nchk++;
    if (o_done[SL+2] !== 1'b1 || o_err[SL+2] !== 2'b00) $display("FAIL bcast_done done=%b err=%b required 1/00", o_done[SL+2], o_err[SL+2]);
    else npass++;
`else
    for (int k = 1; k <= SL + 2; k++) begin
      nchk++;
      if (o_en[k] !== 1'b0 || o_stall[k] !== '0 || o_done[k] !== 1'b0)
        $display("FAIL bank3_nowrite k=%0d en=%b stall=%b done=%b required 0", k, o_en[k], o_stall[k], o_done[k]);
      else npass++;
    end
    nchk++;
    if (o_err[1] !== 2'b01) $display("FAIL bank3_err got %b required 01", o_err[1]);
    else npass++;
`endif
  endtask

  task automatic test_missing_last();
    logic [DW-1:0] exp;
    logic [ZW-1:0] w33, w34;
    logic [AW-1:0] a, a2;
    int b;
    b = $urandom_range(0, NB - 1);
    a = AW'($urandom);
    a2 = AW'($urandom);
    for (int i = 0; i < TQ; i++) words[i] = ZW'($urandom);
    exp = model_row(TQ);
    pulse_err_clr();
    for (int i = 0; i < TQ - 1; i++) beat(BW'(b), a, words[i], 1'b0);
    err_clr = 1'b1;
    beat(BW'(b), a, words[TQ-1], 1'b0);
    err_clr = 1'b0;
    observe(SL + 2);
    nchk++;
    if (o_err[1] !== 2'b01) $display("FAIL missing_last_err got %b required 01 (set over clear)", o_err[1]);
    else npass++;
    nchk++;
    if (o_en[SL+1] !== 1'b1 || o_sel[SL+1] !== onehot(b) || o_addr[SL+1] !== a || o_data[SL+1] !== exp)
      $display("FAIL missing_last_write en=%b sel=%b addr=%0d data=%h required %h", o_en[SL+1], o_sel[SL+1], o_addr[SL+1], o_data[SL+1], exp);
    else npass++;
    nchk++;
    if (o_done[SL+2] !== 1'b1) $display("FAIL missing_last_done got %b required 1", o_done[SL+2]);
    else npass++;
    w33 = ZW'($urandom);
    w34 = ZW'($urandom);
    beat(BW'(b), a2, w33, 1'b0);
    @(negedge clk);
    nchk++;
    if (busy !== 1'b1 || ifc.cfg_ready !== 1'b1 || wr_en !== 1'b0)
      $display("FAIL beat33_fill busy=%b ready=%b en=%b required 1/1/0", busy, ifc.cfg_ready, wr_en);
    else npass++;
    beat(BW'(b), a2 + 4'd1, w34, 1'b1);
    observe(SL + 2);
    words[0] = w33;
    words[1] = w34;
    nchk++;
    if (o_en[SL+1] !== 1'b1 || o_addr[SL+1] !== a2 || o_data[SL+1] !== model_row(2))
      $display("FAIL beat33_row en=%b addr=%0d data=%h required 1/%0d/%h", o_en[SL+1], o_addr[SL+1], o_data[SL+1], a2, model_row(2));
    else npass++;
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp;
    logic [AW-1:0] a;
    int n;
    n = $urandom_range(1, TQ);
    a = AW'($urandom);
    for (int i = 0; i < TQ; i++) words[i] = ZW'($urandom);
    exp = model_row(n);
    pulse_err_clr();
    send_row(2'd0, a, n, 1'b1);
    for (int k = 1; k <= 3 * SL + 1; k++) begin
      @(negedge clk);
      o_stall[k] = stall; o_en[k] = wr_en; o_sel[k] = wr_sel; o_addr[k] = wr_addr;
      o_data[k] = wr_data; o_done[k] = done; o_ready[k] = ifc.cfg_ready; o_busy[k] = busy; o_err[k] = err;
      if (k == SL + 1) vil = 2'b01;
      if (k == SL + 2) vil = 2'b00;
    end
    for (int k = 1; k <= 2 * SL + 3; k++) begin
      nchk++;
      if (o_stall[k] !== ((k <= 2 * SL + 2) ? 2'b01 : 2'b00) || o_en[k] !== (k == SL + 1 || k == 2 * SL + 2) ||
          o_done[k] !== (k == 2 * SL + 3))
        $display("FAIL coll_timeline k=%0d stall=%b en=%b done=%b", k, o_stall[k], o_en[k], o_done[k]);
      else npass++;
    end
    nchk++;
    if (o_err[SL+2] !== 2'b10 || o_busy[SL+2] !== 1'b1) $display("FAIL coll_err err=%b busy=%b required 10/1", o_err[SL+2], o_busy[SL+2]);
    else npass++;
    nchk++;
    if (o_sel[2*SL+2] !== 2'b01 || o_addr[2*SL+2] !== a || o_data[2*SL+2] !== exp)
      $display("FAIL coll_retry sel=%b addr=%0d data=%h required 01/%0d/%h", o_sel[2*SL+2], o_addr[2*SL+2], o_data[2*SL+2], a, exp);
    else npass++;
    nchk++;
    if (o_ready[2*SL+3] !== 1'b1) $display("FAIL coll_ready got %b required 1", o_ready[2*SL+3]);
    else npass++;
  endtask

  task automatic test_reset_mid_stall();
    bit seen;
    for (int i = 0; i < TQ; i++) words[i] = ZW'($urandom);
    send_row(2'd1, 4'd2, 4, 1'b1);
    @(negedge clk);
    nchk++;
    if (stall !== 2'b10) $display("FAIL rst_pre_stall got %b required 10", stall);
    else npass++;
    rst = 1'b1;
    @(negedge clk);
    nchk++;
    if (stall !== '0 || wr_en !== 1'b0 || busy !== 1'b0 || err !== 2'b00)
      $display("FAIL rst_mid stall=%b en=%b busy=%b err=%b required 0", stall, wr_en, busy, err);
    else npass++;
    rst = 1'b0;
    @(negedge clk);
    nchk++;
    if (ifc.cfg_ready !== 1'b1) $display("FAIL rst_mid_ready got %b required 1", ifc.cfg_ready);
    else npass++;
    seen = 1'b0;
    for (int k = 0; k < SL + 3; k++) begin
      if (wr_en !== 1'b0 || stall !== '0 || done !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    nchk++;
    if (seen) $display("FAIL rst_mid_no_write write/stall/done seen=%b required 0", seen);
    else npass++;
  endtask

  initial begin
    ifc.cfg_valid = 1'b0;
    ifc.cfg_bank  = '0;
    ifc.cfg_addr  = '0;
    ifc.cfg_data  = '0;
    ifc.cfg_last  = 1'b0;
    test_reset();
    test_full_row();
    test_short_row();
    test_random_rows();
    test_bad_bank();
    test_missing_last();
    test_collision();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
